// File: rtl/cam_pkg.sv
// cam_pkg: shared types for the CAM management front-end
package cam_pkg;
  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_DELETE = 1'b1
  } cam_op_e;
  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_EXISTS    = 2'b01,
    ST_FULL      = 2'b10,
    ST_NOT_FOUND = 2'b11
  } cam_status_e;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOOKUP = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } cam_wr_state_e;
endpackage

// File: rtl/cam_free_enc.sv
// cam_free_enc: lowest-zero priority encoder over the occupancy bitmap
module cam_free_enc #(
  parameter int DEPTH = 16,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] occ,
  output logic [IW-1:0]    free_idx,
  output logic             any_free
);
  // scan from the top so the lowest free slot wins
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) free_idx = occ[i] ? free_idx : IW'(i);
    any_free = ~&occ;
  end
endmodule

// File: rtl/cam_writer.sv
// cam_writer: insert/delete front-end doing lookup-before-write into the CAM
module cam_writer
  import cam_pkg::*;
#(
  parameter int CAM_WIDTH = 32,
  parameter int CAM_DEPTH = 16,
  localparam int IDX_W = $clog2(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [CAM_WIDTH-1:0] req_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDX_W-1:0]     rsp_idx,
  output logic [1:0]           rsp_status,
  output logic                 cam_we,
  output logic [IDX_W-1:0]     cam_idx,
  output logic [CAM_WIDTH-1:0] cam_data,
  output logic                 cam_vld,
  input  logic                 cam_hit,
  input  logic [IDX_W-1:0]     cam_hit_idx,
  output logic [IDX_W:0]       occ_cnt,
  output logic                 full
);
  cam_wr_state_e          state, state_nxt;
  cam_op_e                op;
  cam_status_e            status;
  logic [CAM_WIDTH-1:0]   key;
  logic [IDX_W-1:0]       idx;
  logic [CAM_DEPTH-1:0]   occ, occ_nxt;
  logic [IDX_W-1:0]       free_idx;
  logic                   any_free;
  logic                   ins;

  assign ins = op == OP_INSERT;

  cam_free_enc #(.DEPTH(CAM_DEPTH)) u_free (
    .occ      (occ),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state: a write is needed for a fresh insert with room, or a delete that hits
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_valid ? LOOKUP : IDLE;
      LOOKUP:  state_nxt = (ins ? (!cam_hit && any_free) : cam_hit) ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = rsp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state; a reset landing on WRITE suppresses the write pulse
  always_comb begin
    req_ready  = state == IDLE;
    rsp_valid  = state == RESP;
    rsp_idx    = idx;
    rsp_status = status;
    cam_we     = state == WRITE && !rst;
    cam_idx    = state == WRITE ? idx : '0;
    cam_vld    = state == WRITE && ins;
    cam_data   = (state == LOOKUP || (state == WRITE && ins)) ? key : '0;
  end

  // occupancy after this cycle's write, so the counters track occ without lag
  always_comb begin
    occ_nxt = occ;
    if (state == WRITE) occ_nxt[idx] = ins;
  end

  // request latch, lookup decision and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= OP_INSERT;
      key     <= '0;
      idx     <= '0;
      status  <= ST_OK;
      occ     <= '0;
      occ_cnt <= '0;
      full    <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        op  <= cam_op_e'(req_op);
        key <= req_key;
      end
      if (state == LOOKUP) begin
        idx    <= cam_hit ? cam_hit_idx : (ins && any_free) ? free_idx : '0;
        status <= cam_hit ? (ins ? ST_EXISTS : ST_OK)
                          : (ins ? (any_free ? ST_OK : ST_FULL) : ST_NOT_FOUND);
      end
      if (state == WRITE) status <= ST_OK;
      occ     <= occ_nxt;
      occ_cnt <= (IDX_W + 1)'($countones(occ_nxt));
      full    <= &occ_nxt;
    end
  end
endmodule

// File: tb/tb_cam_writer.sv
// tb_cam_writer: directed checks of cam_writer against a small behavioural CAM
module tb_cam_writer;
  localparam int W = 32;
  localparam int D = 4;
  localparam int IW = 2;
  localparam logic [1:0] S_OK = 2'd0, S_EX = 2'd1, S_FU = 2'd2, S_NF = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_op = 1'b0;
  logic [W-1:0]  req_key = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready, rsp_valid, cam_we, cam_vld, cam_hit, full;
  logic [IW-1:0] rsp_idx, cam_idx, cam_hit_idx;
  logic [1:0]    rsp_status;
  logic [W-1:0]  cam_data;
  logic [IW:0]   occ_cnt;

  int n_tests = 0;
  int n_fail = 0;

  cam_writer #(.CAM_WIDTH(W), .CAM_DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_key     (req_key),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_idx     (rsp_idx),
    .rsp_status  (rsp_status),
    .cam_we      (cam_we),
    .cam_idx     (cam_idx),
    .cam_data    (cam_data),
    .cam_vld     (cam_vld),
    .cam_hit     (cam_hit),
    .cam_hit_idx (cam_hit_idx),
    .occ_cnt     (occ_cnt),
    .full        (full)
  );

  always #5 clk = ~clk;

  // behavioural CAM: storage written on cam_we, combinational lowest-index match
  logic [W-1:0] cm [D];
  logic         cv [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) cv[i] <= 1'b0;
    end else if (cam_we) begin
      cm[cam_idx] <= cam_data;
      cv[cam_idx] <= cam_vld;
    end
  end

  always_comb begin
    cam_hit     = 1'b0;
    cam_hit_idx = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (cv[i] && cm[i] == cam_data) begin
        cam_hit     = 1'b1;
        cam_hit_idx = IW'(i);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one full request; wr says whether a CAM write cycle is expected before RESP
  task automatic do_req(input string tag, input logic op, input logic [W-1:0] key,
                        input bit wr, input logic [IW-1:0] eidx, input logic [1:0] est);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    tick;
    req_valid = 1'b0;
    chk({tag, ".lk_we"}, cam_we, 0);
    chk({tag, ".lk_data"}, cam_data, key);
    chk({tag, ".lk_rdy"}, req_ready, 0);
    tick;
    if (wr) begin
      chk({tag, ".wr_we"}, cam_we, 1);
      chk({tag, ".wr_idx"}, cam_idx, eidx);
      chk({tag, ".wr_vld"}, cam_vld, !op);
      chk({tag, ".wr_data"}, cam_data, op ? '0 : key);
      chk({tag, ".wr_rspv"}, rsp_valid, 0);
      tick;
    end
    chk({tag, ".rspv"}, rsp_valid, 1);
    chk({tag, ".rsp_we"}, cam_we, 0);
    chk({tag, ".rsp_idx"}, rsp_idx, eidx);
    chk({tag, ".rsp_st"}, rsp_status, est);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk({tag, ".idle_rdy"}, req_ready, 1);
    chk({tag, ".idle_data"}, cam_data, 0);
  endtask

  initial begin
    rst = 1'b1;
    tick;
    tick;
    chk("rst.req_ready", req_ready, 1);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.occ_cnt", occ_cnt, 0);
    chk("rst.full", full, 0);
    chk("rst.cam_we", cam_we, 0);
    chk("rst.cam_data", cam_data, 0);
    chk("rst.rsp_idx", rsp_idx, 0);
    chk("rst.rsp_status", rsp_status, 0);
    rst = 1'b0;
    tick;

    do_req("ins_dead", 1'b0, 32'hDEADBEEF, 1, 2'd0, S_OK);
    chk("ins_dead.occ", occ_cnt, 1);
    do_req("ins_dup", 1'b0, 32'hDEADBEEF, 0, 2'd0, S_EX);
    chk("ins_dup.occ", occ_cnt, 1);
    do_req("del_dead", 1'b1, 32'hDEADBEEF, 1, 2'd0, S_OK);
    chk("del_dead.occ", occ_cnt, 0);

    for (int k = 1; k <= 4; k++) do_req("fill", 1'b0, W'(k), 1, IW'(k - 1), S_OK);
    chk("fill.full", full, 1);
    chk("fill.occ", occ_cnt, 4);
    do_req("ins_full", 1'b0, 32'd5, 0, 2'd0, S_FU);
    chk("ins_full.occ", occ_cnt, 4);

    do_req("del2", 1'b1, 32'd2, 1, 2'd1, S_OK);
    chk("del2.occ", occ_cnt, 3);
    chk("del2.full", full, 0);
    do_req("ins9", 1'b0, 32'd9, 1, 2'd1, S_OK);
    chk("ins9.full", full, 1);

    req_valid = 1'b1;
    req_op    = 1'b1;
    req_key   = 32'h55;
    tick;
    req_valid = 1'b0;
    chk("nf.lk_we", cam_we, 0);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("nf.rspv", rsp_valid, 1);
      chk("nf.idx", rsp_idx, 0);
      chk("nf.st", rsp_status, S_NF);
      chk("nf.rdy", req_ready, 0);
      chk("nf.we", cam_we, 0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("nf.idle_rdy", req_ready, 1);

    do_req("del3", 1'b1, 32'd3, 1, 2'd2, S_OK);

    req_valid = 1'b1;
    req_op    = 1'b0;
    req_key   = 32'h77;
    tick;
    req_valid = 1'b0;
    tick;
    chk("rw.pre_we", cam_we, 1);
    rst = 1'b1;
    #1;
    chk("rw.we_dropped", cam_we, 0);
    tick;
    chk("rw.occ", occ_cnt, 0);
    chk("rw.full", full, 0);
    chk("rw.req_ready", req_ready, 1);
    chk("rw.rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    tick;
    do_req("ins_after_rst", 1'b0, 32'h77, 1, 2'd0, S_OK);
    chk("ins_after_rst.occ", occ_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
